program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 93 +++++++++
 tb/tb_program_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: loads a length-prefixed byte stream into instruction memory, then releases the CPU.
// Optional trailing checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, FLUSH, RUN, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN, DATA, FLUSH, RUN, ERR} state_t;
`endif
    localparam logic [8:0] CAP = 9'(2 ** ADDR_W);
    state_t state, state_nx;
    logic [8:0] cnt, len, n;
    logic xfer, last;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] acc;
`endif
    assign xfer = in_valid && in_ready;
    assign n = in_data == 8'd0 ? 9'd256 : {1'b0, in_data};
    assign last = cnt + 9'd1 == len;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, RUN, ERR: state_nx = start ? LEN : state;
            LEN: state_nx = xfer ? (n > CAP ? ERR : DATA) : LEN;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            DATA: state_nx = xfer && last ? CHK : DATA;
            CHK: state_nx = xfer ? (in_data == acc ? FLUSH : ERR) : CHK;
`else
            DATA: state_nx = xfer && last ? FLUSH : DATA;
`endif
            FLUSH: state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    // Status outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            len <= '0;
            in_ready <= 1'b0;
            imem_we <= 1'b0;
            imem_addr <= '0;
            imem_wdata <= '0;
            cpu_reset <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            imem_we <= state == DATA && xfer;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            in_ready <= state_nx inside {LEN, DATA, CHK};
`else
            in_ready <= state_nx inside {LEN, DATA};
`endif
            cpu_reset <= state_nx == RUN;
            done <= state_nx == RUN;
            err <= state_nx == ERR;
            if (state == LEN && xfer) begin
                cnt <= '0;
                len <= n;
            end
            if (state == DATA && xfer) begin
                imem_addr <= cnt[ADDR_W-1:0];
                imem_wdata <= in_data;
                cnt <= cnt + 9'd1;
            end
        end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) acc <= '0;
        else if (state != LEN && state_nx == LEN) acc <= '0;
        else if (state == DATA && xfer) acc <= acc + in_data;
    end
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed scoreboard bench for program_loader (ADDR_W=8 and ADDR_W=4 instances).
module tb_program_loader;
    logic clk = 1'b0, reset = 1'b0;
    logic start = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, imem_we, cpu_reset, done, err;
    logic [7:0] imem_addr, imem_wdata;
    logic start4 = 1'b0, in_valid4 = 1'b0;
    logic [7:0] in_data4 = 8'h00;
    logic in_ready4, imem_we4, cpu_reset4, done4, err4;
    logic [3:0] imem_addr4;
    logic [7:0] imem_wdata4;
    int n_cmp = 0, n_err = 0;
    logic [15:0] q8[$], q4[$];
    logic [15:0] e8, e4;
    logic [7:0] prog[$];

    program_loader #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .done(done), .err(err)
    );
    program_loader #(.ADDR_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .in_valid(in_valid4), .in_data(in_data4),
        .in_ready(in_ready4), .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
        .cpu_reset(cpu_reset4), .done(done4), .err(err4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the next expected (addr, data) pair.
    always @(negedge clk) begin
        if (imem_we) begin
            check("we8_expected", 32'(imem_we), 32'(q8.size() != 0));
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                check("imem_addr8", 32'(imem_addr), 32'(e8[15:8]));
                check("imem_wdata8", 32'(imem_wdata), 32'(e8[7:0]));
            end
        end
        if (imem_we4) begin
            check("we4_expected", 32'(imem_we4), 32'(q4.size() != 0));
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                check("imem_addr4", 32'(imem_addr4), 32'(e4[11:8]));
                check("imem_wdata4", 32'(imem_wdata4), 32'(e4[7:0]));
            end
        end
    end

    task automatic pulse(input bit s);
        if (s) start4 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic send(input bit s, input logic [7:0] b);
        int t = 0;
        if (s) begin in_valid4 = 1'b1; in_data4 = b; end
        else begin in_valid = 1'b1; in_data = b; end
        @(negedge clk);
        while (!(s ? in_ready4 : in_ready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("in_ready", 32'(s ? in_ready4 : in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_valid4 = 1'b0;
    endtask

    task automatic load(input bit s, input int gap, input bit do_start);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        logic [7:0] sum = 8'h00;
`endif
        if (do_start) pulse(s);
        send(s, 8'(prog.size()));
        foreach (prog[i]) begin
            repeat (gap) @(posedge clk);
            if (gap > 0) #1;
            if (s) q4.push_back({8'(i), prog[i]});
            else q8.push_back({8'(i), prog[i]});
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum += prog[i];
`endif
            send(s, prog[i]);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send(s, sum);
`endif
        check("flush_done", 32'(s ? done4 : done), 32'd0);
        check("flush_cpu_reset", 32'(s ? cpu_reset4 : cpu_reset), 32'd0);
        @(posedge clk); #1;
        check("run_done", 32'(s ? done4 : done), 32'd1);
        check("run_cpu_reset", 32'(s ? cpu_reset4 : cpu_reset), 32'd1);
        check("run_in_ready", 32'(s ? in_ready4 : in_ready), 32'd0);
        check("run_err", 32'(s ? err4 : err), 32'd0);
        check("q_drained", 32'(s ? q4.size() : q8.size()), 32'd0);
    endtask

    initial begin
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cpu_reset4", 32'(cpu_reset4), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        prog = '{8'h41, 8'h82, 8'hC7};
        load(1'b0, 0, 1'b1);
        load(1'b0, 5, 1'b1);
        pulse(1'b0);
        check("restart_cpu_reset", 32'(cpu_reset), 32'd0);
        check("restart_done", 32'(done), 32'd0);
        check("restart_in_ready", 32'(in_ready), 32'd1);
        prog = '{8'h5A, 8'hA5};
        load(1'b0, 0, 1'b0);
        pulse(1'b0);
        send(1'b0, 8'h04);
        q8.push_back({8'h00, 8'h11});
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        reset = 1'b0;
        #1;
        check("mid_rst_imem_we", 32'(imem_we), 32'd0);
        check("mid_rst_imem_addr", 32'(imem_addr), 32'd0);
        check("mid_rst_imem_wdata", 32'(imem_wdata), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        in_valid = 1'b1;
        in_data = 8'h33;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        prog = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load(1'b0, 0, 1'b1);
        prog.delete();
        for (int i = 0; i < 256; i++) prog.push_back(8'(i * 7 + 3));
        load(1'b0, 0, 1'b1);
        pulse(1'b1);
        send(1'b1, 8'h11);
        check("oversize_err4", 32'(err4), 32'd1);
        check("oversize_cpu_reset4", 32'(cpu_reset4), 32'd0);
        check("oversize_in_ready4", 32'(in_ready4), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("oversize_err4_held", 32'(err4), 32'd1);
        prog.delete();
        for (int i = 0; i < 16; i++) prog.push_back(8'(8'hF0 - i));
        load(1'b1, 0, 1'b1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        prog = '{8'h10, 8'h20};
        load(1'b0, 0, 1'b1);
        pulse(1'b0);
        send(1'b0, 8'h02);
        q8.push_back({8'h00, 8'h10});
        send(1'b0, 8'h10);
        q8.push_back({8'h01, 8'h20});
        send(1'b0, 8'h20);
        send(1'b0, 8'h31);
        check("bad_chk_err", 32'(err), 32'd1);
        check("bad_chk_cpu_reset", 32'(cpu_reset), 32'd0);
        check("bad_chk_done", 32'(done), 32'd0);
        pulse(1'b0);
        check("err_restart_in_ready", 32'(in_ready), 32'd1);
        check("err_restart_err", 32'(err), 32'd0);
        prog = '{8'h77};
        load(1'b0, 0, 1'b0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("final_q8", 32'(q8.size()), 32'd0);
        check("final_q4", 32'(q4.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
